// File: rtl/dected_pkg.sv
// Shared constants, H column tables and codeword layout for the 32-bit DECTED ECC path.
// The syndrome decoders import this same package so the H matrix has a single source.
package dected_pkg;

    localparam int DATA_W  = 32;
    localparam int CHK_W   = 8;
    localparam int CW_W    = DATA_W + 2 * CHK_W + 1;
    localparam int N_BYTES = DATA_W / 8;

    // Codeword field offsets: {parity, chk_b, chk_a, data}
    localparam int DATA_LSB   = 0;
    localparam int CHK_A_LSB  = DATA_W;
    localparam int CHK_B_LSB  = DATA_W + CHK_W;
    localparam int PARITY_BIT = DATA_W + 2 * CHK_W;

    typedef logic [CHK_W-1:0] chk_t;

    typedef struct packed {
        logic              parity;
        chk_t              chk_b;
        chk_t              chk_a;
        logic [DATA_W-1:0] data;
    } cw_t;

    // Group A columns: the 32 lowest distinct weight-3 bytes
    localparam chk_t H_A [DATA_W] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62
    };

    // Group B columns: all 32 entries are distinct and nonzero
    localparam chk_t H_B [DATA_W] = '{
        8'h98, 8'h51, 8'h13, 8'hD0, 8'h31, 8'h29, 8'h45, 8'hC4,
        8'h52, 8'h8A, 8'h62, 8'hA1, 8'h1C, 8'h86, 8'h0B, 8'h70,
        8'h8C, 8'h25, 8'h4A, 8'hE0, 8'h16, 8'hA8, 8'h43, 8'h0E,
        8'h94, 8'h38, 8'hC1, 8'h2A, 8'h61, 8'h85, 8'h54, 8'h0D
    };

endpackage

// File: rtl/dected_chk_byte.sv
// Per-byte partial check group: XOR of the H columns selected by one data byte.
module dected_chk_byte
    import dected_pkg::*;
#(
    parameter int BYTE_IDX = 0,
    parameter bit USE_B    = 1'b0
) (
    input  logic [7:0] byte_data,
    output chk_t       partial
);

    logic [4:0] col;

    // Accumulate the columns of every set bit in this byte
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        partial = '0;
        col     = '0;
        for (int j = 0; j < 8; j++) begin
            col = 5'(BYTE_IDX * 8 + j);
            if (byte_data[j]) begin
                partial = partial ^ (USE_B ? H_B[col] : H_A[col]);
            end
        end
    end

endmodule

// File: rtl/dected_encoder.sv
// DECTED check-bit generator: 2-stage valid/ready pipeline producing
// {parity, chk_B, chk_A, data} with an armed single-word error-injection path.
module dected_encoder
    import dected_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inj_arm,
    input  logic [CW_W-1:0]   inj_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_cw,
    output logic              inj_pending
);

    chk_t               part_a [N_BYTES];
    chk_t               part_b [N_BYTES];
    logic [N_BYTES-1:0] in_bpar;

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    chk_t               s1_part_a [N_BYTES];
    chk_t               s1_part_b [N_BYTES];
    logic [N_BYTES-1:0] s1_bpar;
    logic [CW_W-1:0]    s1_inj;

    logic [CW_W-1:0]    armed_mask;
    logic [CW_W-1:0]    inj_sel;
    logic               s2_load;
    logic               accept;
    chk_t               chk_a;
    chk_t               chk_b;
    cw_t                clean_cw;

    // Per-byte partials for both tables plus byte parity, ahead of stage 1
    for (genvar b = 0; b < N_BYTES; b++) begin : g_byte
        dected_chk_byte #(.BYTE_IDX(b), .USE_B(1'b0)) u_part_a (
            .byte_data (in_data[8*b +: 8]),
            .partial   (part_a[b])
        );
        dected_chk_byte #(.BYTE_IDX(b), .USE_B(1'b1)) u_part_b (
            .byte_data (in_data[8*b +: 8]),
            .partial   (part_b[b])
        );
        assign in_bpar[b] = ^in_data[8*b +: 8];
    end

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // A same-cycle arm takes priority over an older armed mask
    assign inj_sel = inj_arm ? inj_mask : (inj_pending ? armed_mask : '0);

    // Injection arming: latched on inj_arm, consumed by the next accepted word
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            inj_pending <= 1'b0;
            armed_mask  <= '0;
        end else if (accept) begin
            inj_pending <= 1'b0;
        end else if (inj_arm) begin
            inj_pending <= 1'b1;
            armed_mask  <= inj_mask;
        end
    end

    // Stage 1: register data, partials, byte parity and the injection mask
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the valid flag needs reset; payload registers are don't-care while invalid.
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_data   <= in_data;
            s1_part_a <= part_a;
            s1_part_b <= part_b;
            s1_bpar   <= in_bpar;
            s1_inj    <= inj_sel;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Fold partials into the final check groups and overall parity
    always_comb begin
        chk_a = '0;
        chk_b = '0;
        for (int b = 0; b < N_BYTES; b++) begin
            chk_a = chk_a ^ s1_part_a[b];
            chk_b = chk_b ^ s1_part_b[b];
        end
        clean_cw.data   = s1_data;
        clean_cw.chk_a  = chk_a;
        clean_cw.chk_b  = chk_b;
        clean_cw.parity = (^s1_bpar) ^ (^chk_a) ^ (^chk_b);
    end

    // Stage 2: output register; mask applied after parity so faults are genuine
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_cw    <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_cw <= clean_cw ^ s1_inj;
            end
        end
    end

endmodule

// File: doc/dected_encoder.md
Name: dected_encoder

Overview:
- Check-bit generator for the 32-bit DECTED ECC path. It is the write-side counterpart of the syndrome decoders.
- Accepts a 32-bit data word over a valid/ready handshake and computes two 8-bit check groups (A, B) plus an overall parity bit.
- Emits a 49-bit codeword through a 2-stage pipeline with full backpressure.
- Includes an armed error-injection path so decoder benches can be driven with known single, double and triple faults.

Parameters:
- DATA_W, 32, data width; fixed by the H tables, other values unsupported.
- CHK_W, 8, width of each check group (A and B).
- CW_W, 49, codeword width = DATA_W + 2*CHK_W + 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder can accept this cycle.
- in_data  in  32  data word.
- inj_arm  in  1  one-cycle pulse; arms injection for the next accepted word.
- inj_mask  in  49  bits to flip; sampled when inj_arm=1.
- out_valid  out  1  codeword valid.
- out_ready  in  1  consumer accepts.
- out_cw  out  49  {parity, chk_B[7:0], chk_A[7:0], data[31:0]}.
- inj_pending  out  1  injection armed, not yet applied.

Behaviour:
- Reset: all valid flags, the armed mask and inj_pending clear. After reset, in_ready=1, out_valid=0, out_cw=0. Reset mid-transfer drops in-flight words with no partial output.
- Check bits:
  - chk_A = XOR over i with data[i]=1 of H_A[i].
  - chk_B = XOR over i with data[i]=1 of H_B[i].
  - H_B[0..10] = 152,81,19,208,49,41,69,196,82,138,98; remaining H_B and all H_A entries come from the package.
  - A single flip of data bit i therefore yields decoder syndrome B = H_B[i].
- parity = XOR of data, chk_A and chk_B, so the whole 49-bit codeword has even parity.
- Stage 1 (s1):
  - On in_valid && in_ready, registers data plus four per-byte partials for A and for B (XOR of that byte's columns) and a byte-parity vector.
  - Also latches inj_applied = armed mask, or zero if not armed.
- Stage 2 (s2):
  - Folds the partials into chk_A/chk_B and computes parity.
  - Registers out_cw = clean codeword XOR inj_applied.
  - The mask is applied after parity, so injected faults are genuine faults.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+2.
  - One word per cycle when out_ready stays high.
- Advance rules:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances when its load condition holds.
  - in_ready = !s1_valid || (s1 advancing). Combinational, no dependence on in_valid.
- Stall: while out_valid && !out_ready, out_cw and out_valid hold stable and no word is lost or duplicated.
- Injection:
  - inj_arm stores the mask and sets inj_pending.
  - The mask is consumed by the next accepted word, and inj_pending clears in the accept cycle.
  - inj_arm in the same cycle as an accept applies the new mask to that word.
  - inj_arm while already pending overwrites the mask.
  - inj_mask=0 with inj_arm still consumes one word (a clean word).
- No wrap or overflow state exists; all arithmetic is GF(2) XOR.

Decomposition:
- Package dected_pkg holds:
  - DATA_W, CHK_W, CW_W constants;
  - H_A and H_B column tables as 32-entry arrays of 8-bit values;
  - field-offset constants for the codeword layout.
  - The decoders share this package so H stays single-source.
- One sub-module, dected_chk_byte: combinational per-byte partial for one H table. It is instantiated 8 times in s1 (4 bytes x tables A/B).

Test Plan:
- Zero: in_data=0x00000000, out_ready=1. Expect out_cw=0 exactly 2 cycles after accept.
- Single bit: in_data=0x00000001. Expect chk_B=0x98 and chk_A=H_A[0]. Expect parity such that popcount(out_cw) is even. Repeat for bits 1..10 (chk_B=0x51,0x13,0xD0,0x31,0x29,0x45,0xC4,0x52,0x8A,0x62).
- Linearity: in_data=0x00000003. Expect chk_B=0xC9 (0x98^0x51); random words must match a reference XOR model for 1000 vectors.
- Backpressure:
  - Stream 6 words back-to-back with out_ready=0 for 5 cycles from the first out_valid.
  - Expect out_cw stable during the stall and in_ready=0 once both stages are full.
  - Expect all 6 words delivered in order with none lost or duplicated.
- Injection: pulse inj_arm with inj_mask=1<<5, then send 0x00000000. Expect out_cw=0x20 and inj_pending 1->0 at accept; the next word is clean.
- Reset mid-stream: assert rst with both stages valid. Expect out_valid=0, in_ready=1 and inj_pending=0 on the next edge, and no stale codeword afterwards.
